vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the vga640x480 timing generator.
- Watches HS/VS (negative-polarity 640x480@60 timing) on the pixel-strobe grid and recovers the pixel coordinate, data-enable and frame-start.
- Checks every line and frame length against nominal timing and reports lock/errors.
- Used to check the generator in loopback and to drive pixel logic from externally timed syncs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, HS low width in strobes
- H_BP, 48, back porch in strobes
- H_TOTAL, 800, strobes per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, VS low width in lines
- V_BP, 33, vertical back porch in lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames before lock (1..7)

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel strobe, one i_clk wide (25 MHz rate)
- i_hs  in  1  horizontal sync, active low
- i_vs  in  1  vertical sync, active low
- o_x  out  10  recovered pixel column
- o_y  out  9  recovered line
- o_de  out  1  active-video enable
- o_frame_start  out  1  one-i_clk pulse at frame origin
- o_locked  out  1  timing locked
- o_err  out  1  one-i_clk pulse on any length mismatch or timeout

Behaviour:
- Async reset (i_rst_n=0) clears everything:
  - outputs o_x=0, o_y=0, o_de=0, o_frame_start=0, o_locked=0, o_err=0
  - internal hcnt=0, vcnt=0, hs_q=1, vs_q=1, vs_armed=0, frame_ref=0, clean_cnt=0
- All state advances only on i_clk edges with i_pix_stb=1. Pulse outputs are forced to 0 on every other edge.
- Edge detection: hs_fall = hs_q & ~i_hs and vs_fall = vs_q & ~i_vs. hs_q/vs_q are reloaded each strobe.
- Horizontal:
  - On hs_fall: hcnt<=0.
  - Otherwise: hcnt<=hcnt+1, saturating at 1023.
  - hs_fall with hcnt!=H_TOTAL-1 is a line error. The first hs_fall after reset is exempt.
- Vertical:
  - vs_fall: performs the frame check; sets frame_ref=1 and vs_armed=1.
  - Frame check: frame_ref=1 and vcnt!=V_TOTAL-1 is a frame error.
  - hs_fall with vs_armed (or simultaneous with vs_fall): vcnt<=0, clear vs_armed, o_frame_start<=1.
  - Other hs_fall: vcnt<=vcnt+1, saturating at 1023.
- Timeout: hcnt reaching H_TOTAL+1 without hs_fall is an error, signalled once per stall.
- Any error:
  - o_err<=1 for one i_clk, o_locked<=0, clean_cnt<=0.
  - The frame in progress is not clean.
- Lock counting:
  - Each error-free frame check increments clean_cnt, saturating at LOCK_FRAMES.
  - o_locked<=1 when clean_cnt reaches LOCK_FRAMES.
  - The first vs_fall after reset only sets frame_ref and counts nothing.
- Active window (next-state counters):
  - hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144,783]
  - vcnt in [V_SYNC+V_BP-1, V_SYNC+V_BP+V_ACTIVE-2] = [34,513]
- Outputs in the window with o_locked=1 (the value after this edge):
  - o_de<=1, o_x<=hcnt-144, o_y<=vcnt-34
- Otherwise o_de<=0, o_x<=0, o_y<=0.
- Latency: one strobe. For generator pixel (0,0), o_de rises on the strobe edge after the generator presents it.
- Reset mid-frame: all state clears. Lock is re-acquired only after LOCK_FRAMES complete clean frames following the first vs_fall.
- Width rules: x is 10 bits (0..639), y is 9 bits (0..479). Subtractions are truncated to these widths and valid only while o_de=1.

Test Plan:
- Loopback from the timing generator, reset released at frame start:
  - first vs_fall produces no lock change
  - o_locked rises at the 3rd vs_fall (LOCK_FRAMES=2)
  - o_err never pulses
- Locked loopback, compare every o_de strobe against the generator's active x/y delayed one strobe:
  - exactly 640x480=307200 o_de strobes per frame
  - first is (0,0), last (639,479)
  - one o_frame_start per frame, 525 lines apart
- Lengthen one line to 801 strobes:
  - o_err pulses once at that hs_fall and o_locked drops on the same edge
  - re-lock after 2 clean frames following the next vs_fall
- Hold i_hs high for 1000 strobes:
  - single o_err at hcnt=801, o_locked=0, o_de stays 0
  - counters saturate at 1023
- Frame of 524 lines (drop one line): o_err at the following vs_fall, o_locked 1->0.
- Assert i_rst_n=0 asynchronously mid-line (no clock edge):
  - all outputs 0 immediately
  - after release, o_locked=0 until 2 clean frames pass

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, data-enable and frame start from externally timed
// negative-polarity HS/VS, and tracks line/frame length lock against nominal timing.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_de,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
);

  localparam int unsigned CW = 10;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned LW = 3;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_STALL  = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_WIN_LO = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_WIN_HI = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_WIN_LO = CW'(V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] V_WIN_HI = CW'(V_SYNC + V_BP + V_ACTIVE - 2);
  localparam logic [LW-1:0] LOCK_N   = LW'(LOCK_FRAMES);

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          vs_armed_q, vs_armed_d;
  logic          frame_ref_q, frame_ref_d;
  logic          line_ref_q, line_ref_d;
  logic          dirty_q, dirty_d;
  logic [LW-1:0] clean_q, clean_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          fs_q, fs_d;
  logic          de_q, de_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic hs_fall, vs_fall, line_err, tmo_err, frame_err, any_err, in_win;

  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    vs_armed_d  = vs_armed_q;
    frame_ref_d = frame_ref_q;
    line_ref_d  = line_ref_q;
    dirty_d     = dirty_q;
    clean_d     = clean_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    fs_d        = 1'b0;
    de_d        = de_q;
    x_d         = x_q;
    y_d         = y_q;
    hs_fall     = 1'b0;
    vs_fall     = 1'b0;
    line_err    = 1'b0;
    tmo_err     = 1'b0;
    frame_err   = 1'b0;
    any_err     = 1'b0;
    in_win      = 1'b0;

    if (i_pix_stb) begin
      hs_fall   = hs_q & ~i_hs;
      vs_fall   = vs_q & ~i_vs;
      hs_d      = i_hs;
      vs_d      = i_vs;
      line_err  = hs_fall & line_ref_q & (hcnt_q != H_LAST);
      tmo_err   = ~hs_fall & (hcnt_q == H_STALL);
      frame_err = vs_fall & frame_ref_q & (vcnt_q != V_LAST);
      any_err   = line_err | tmo_err | frame_err;

      if (hs_fall) begin
        hcnt_d     = '0;
        line_ref_d = 1'b1;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + CW'(1);
      end

      // VS only arms; the frame origin is the HS edge that consumes the arm
      if (vs_fall) begin
        frame_ref_d = 1'b1;
        vs_armed_d  = 1'b1;
      end
      if (hs_fall && (vs_armed_q || vs_fall)) begin
        vcnt_d     = '0;
        vs_armed_d = 1'b0;
        fs_d       = 1'b1;
      end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
        vcnt_d = vcnt_q + CW'(1);
      end

      if (any_err) begin
        clean_d  = '0;
        locked_d = 1'b0;
      end else if (vs_fall && frame_ref_q && !dirty_q && (clean_q != LOCK_N)) begin
        clean_d = clean_q + LW'(1);
      end
      if (!any_err && (clean_d == LOCK_N)) locked_d = 1'b1;

      // an error on the VS edge itself is charged to the frame that just ended
      if (vs_fall)      dirty_d = 1'b0;
      else if (any_err) dirty_d = 1'b1;
      err_d = any_err;

      in_win = locked_d && (hcnt_d >= H_WIN_LO) && (hcnt_d <= H_WIN_HI) &&
               (vcnt_d >= V_WIN_LO) && (vcnt_d <= V_WIN_HI);
      de_d   = in_win;
      x_d    = in_win ? XW'(hcnt_d - H_WIN_LO) : '0;
      y_d    = in_win ? YW'(vcnt_d - V_WIN_LO) : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      vs_armed_q  <= 1'b0;
      frame_ref_q <= 1'b0;
      line_ref_q  <= 1'b0;
      dirty_q     <= 1'b0;
      clean_q     <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      fs_q        <= 1'b0;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vs_armed_q  <= vs_armed_d;
      frame_ref_q <= frame_ref_d;
      line_ref_q  <= line_ref_d;
      dirty_q     <= dirty_d;
      clean_q     <= clean_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      fs_q        <= fs_d;
      de_q        <= de_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_de          = de_q;
  assign o_frame_start = fs_q;
  assign o_locked      = locked_q;
  assign o_err         = err_q;

endmodule
